n_bit_deserializer: RTL and testbench
=====================================

# n_bit_deserializer

Serial-in, parallel-out front end that assembles an `n`-bit word from a framed serial bit stream and presents it to the downstream `n`-bit register. `out_word` drives the register's data input and `out_load` drives its enable, so one completed frame produces exactly one register load. Bits may arrive with gaps. A new start strobe aborts a partial frame.

## Interface

- `n`, default 8: word width in bits; must be ≥ 2.
- `msb_first`, default 0: bit order. 0 places the first received bit in `out_word[0]`; 1 places it in `out_word[n-1]`.

- `in_clk`, input, 1: single clock; all state changes on its rising edge.
- `in_res`, input, 1: reset, synchronous, active-high.
- `in_start`, input, 1: frame start strobe. The start cycle carries no data bit.
- `in_bit`, input, 1: serial data bit, sampled only when `in_bit_valid` = 1 in state SHIFT.
- `in_bit_valid`, input, 1: qualifies `in_bit`.
- `out_word`, output, n: last completed word; held until the next completion.
- `out_load`, output, 1: one-cycle pulse when `out_word` has just been updated; connects to the register enable.
- `out_busy`, output, 1: high while in state SHIFT.
- `out_restart`, output, 1: one-cycle pulse after a partial frame is aborted by `in_start`.

## Operation

- **Internal state:**
  - n-bit shift register `sr`.
  - Bit counter `cnt`, width clog2(n+1).
  - State register with states IDLE, SHIFT, DONE.
- **Reset** (`in_res` = 1 at an edge): state ← IDLE, `cnt` ← 0, `sr` ← 0, `out_word` ← 0, `out_load` ← 0, `out_busy` ← 0, `out_restart` ← 0. Reset takes priority over all other inputs. A reset mid-frame discards the partial word and produces no `out_load`.
- **IDLE:**
  - `in_start` = 1 → SHIFT, `cnt` ← 0, `sr` ← 0.
  - `in_bit_valid` is ignored, including in the same cycle as `in_start`.
- **SHIFT:**
  - `in_start` = 1 takes priority over a valid bit. Then: `cnt` ← 0, `sr` ← 0, stay in SHIFT, `out_restart` = 1 in the next cycle. The bit in that cycle is discarded.
  - Otherwise, if `in_bit_valid` = 1, insert `in_bit` and increment `cnt`.
    - `msb_first` = 0: `sr` ← {`in_bit`, `sr[n-1:1]`}.
    - `msb_first` = 1: `sr` ← {`sr[n-2:0]`, `in_bit`}.
  - On the edge that captures the nth bit (`cnt` = n-1 and valid): `out_word` ← the assembled word including that bit, state → DONE, `cnt` ← 0.
  - `in_bit_valid` = 0: hold all state. There is no timeout.
- **DONE** (exactly one cycle):
  - `out_load` = 1 and `out_busy` = 0.
  - `in_start` = 1 → SHIFT (back-to-back frames); otherwise → IDLE.
  - `in_bit_valid` is ignored.
- **Output rules:**
  - `out_word` never changes except on frame completion or reset.
  - `out_load`, `out_restart` and `out_busy` are registered outputs; none is driven combinationally from inputs.

## Timing

- Start strobe in cycle 0 with continuous valid bits in cycles 1..n gives:
  - `out_busy` high in cycles 1..n;
  - `out_word` updated and `out_load` high in cycle n+1;
  - the downstream register captures the word on the edge ending cycle n+1.
- Latency from the last data bit to `out_load` is 1 cycle.
- Each cycle of `in_bit_valid` = 0 within a frame extends the frame by one cycle.
- Minimum frame period is n+1 cycles: the start strobe is accepted in the DONE cycle.
- `out_restart` is high in the cycle after the aborting `in_start`, while `out_busy` remains high.
- `in_res` asserted in any cycle: all outputs read reset values in the following cycle.

## Test plan

- **LSB-first single frame.** `n`=8, `msb_first`=0; start in cycle 0, then bits 1,0,1,0,0,1,0,1 in cycles 1–8 → `out_word`=0xA5 and `out_load`=1 in cycle 9 only; `out_busy` high in cycles 1–8.
- **Bit order.** Bit stream 1,0,0,0,0,0,0,0: `msb_first`=0 → `out_word`=0x01; `msb_first`=1 → `out_word`=0x80.
- **Gapped valid.** Same 0xA5 stream with `in_bit_valid` low every other cycle → `out_word`=0xA5, `out_load` 16 cycles after start. `out_word` keeps its previous value throughout the frame.
- **Abort.** 3 bits sent, then `in_start` with `in_bit_valid`=1 and `in_bit`=1 → `out_restart` pulse; that bit is discarded. Next 8 bits 0xFF → `out_word`=0xFF, exactly one `out_load`.
- **Back-to-back.** Start asserted in the DONE cycle of frame 0x12, followed by frame 0x34 → `out_load` pulses exactly 9 cycles apart, `out_word` 0x12 then 0x34.
- **Reset mid-frame.** `in_res` pulsed after 5 bits → all outputs 0 and no `out_load`. A bit stream without a new start is ignored. A new frame of 0x5A then completes normally.

Source files
------------

// File: rtl/n_bit_deserializer.sv
// Framed serial-in, parallel-out deserializer: assembles an n-bit word from a
// gapped bit stream and pulses out_load once per completed frame.
module n_bit_deserializer #(
   parameter int unsigned n         = 8,
   parameter bit          msb_first = 1'b0
) (
   input  logic         in_clk,
   input  logic         in_res,
   input  logic         in_start,
   input  logic         in_bit,
   input  logic         in_bit_valid,
   output logic [n-1:0] out_word,
   output logic         out_load,
   output logic         out_busy,
   output logic         out_restart
);

   localparam int unsigned CNT_W = $clog2(n + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(n - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [n-1:0]     sr_q, sr_d;
   logic [n-1:0]     word_q, word_d;
   logic             load_q, load_d;
   logic             busy_q, busy_d;
   logic             restart_q, restart_d;
   logic [n-1:0]     sr_ins_c;

   // Shift register contents after inserting the current bit in the configured order
   always_comb begin
      if (msb_first) begin
         sr_ins_c = {sr_q[n-2:0], in_bit};
      end else begin
         sr_ins_c = {in_bit, sr_q[n-1:1]};
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      word_d    = word_q;
      restart_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (in_start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               sr_d    = '0;
            end
         end
         SHIFT: begin
            if (in_start) begin
               // Abort: the bit presented with the strobe is dropped
               cnt_d     = '0;
               sr_d      = '0;
               restart_d = 1'b1;
            end else if (in_bit_valid) begin
               sr_d = sr_ins_c;
               if (cnt_q == LAST_CNT) begin
                  word_d  = sr_ins_c;
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (in_start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               sr_d    = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_d    = '0;
         end
      endcase

      busy_d = (state_d == SHIFT);
      load_d = (state_d == DONE);
   end

   always_ff @(posedge in_clk) begin
      if (in_res) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sr_q      <= '0;
         word_q    <= '0;
         load_q    <= 1'b0;
         busy_q    <= 1'b0;
         restart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sr_q      <= sr_d;
         word_q    <= word_d;
         load_q    <= load_d;
         busy_q    <= busy_d;
         restart_q <= restart_d;
      end
   end

   assign out_word    = word_q;
   assign out_load    = load_q;
   assign out_busy    = busy_q;
   assign out_restart = restart_q;

endmodule

// File: tb/tb_n_bit_deserializer.sv
// Bench for n_bit_deserializer: LSB-first and MSB-first instances share one
// input stream and are compared every cycle against a frame-level model.
module tb_n_bit_deserializer;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         res, start, dbit, dvalid;
   logic [N-1:0] word_l, word_m;
   logic         load_l, busy_l, rst_l;
   logic         load_m, busy_m, rst_m;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int start_cyc, last_load, prev_load, loads_seen;

   // Model: a frame is either open (collecting bits) or not
   bit           m_active = 1'b0;
   bit           m_bits[$];
   logic [N-1:0] e_word_l = '0, e_word_m = '0;
   logic         e_load = 1'b0, e_busy = 1'b0, e_restart = 1'b0;

   n_bit_deserializer #(.n(N), .msb_first(1'b0)) dut_lsb (
      .in_clk(clk), .in_res(res), .in_start(start), .in_bit(dbit),
      .in_bit_valid(dvalid), .out_word(word_l), .out_load(load_l),
      .out_busy(busy_l), .out_restart(rst_l));

   n_bit_deserializer #(.n(N), .msb_first(1'b1)) dut_msb (
      .in_clk(clk), .in_res(res), .in_start(start), .in_bit(dbit),
      .in_bit_valid(dvalid), .out_word(word_m), .out_load(load_m),
      .out_busy(busy_m), .out_restart(rst_m));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Apply one cycle of inputs, advance the model, check every output
   task automatic step(input logic s, input logic v, input logic b, input logic r);
      start = s; dvalid = v; dbit = b; res = r;
      @(posedge clk);
      #1;
      cyc++;
      e_load    = 1'b0;
      e_restart = 1'b0;
      if (r) begin
         m_active = 1'b0;
         m_bits.delete();
         e_word_l = '0;
         e_word_m = '0;
      end else if (m_active) begin
         if (s) begin
            m_bits.delete();
            e_restart = 1'b1;
         end else if (v) begin
            m_bits.push_back(b);
            if (m_bits.size() == N) begin
               for (int i = 0; i < N; i++) begin
                  e_word_l[i]     = m_bits[i];
                  e_word_m[N-1-i] = m_bits[i];
               end
               m_bits.delete();
               m_active = 1'b0;
               e_load   = 1'b1;
            end
         end
      end else if (s) begin
         m_active = 1'b1;
         m_bits.delete();
      end
      e_busy = m_active;

      chk("word_lsb", 32'(word_l), 32'(e_word_l));
      chk("word_msb", 32'(word_m), 32'(e_word_m));
      chk("load_lsb", 32'(load_l), 32'(e_load));
      chk("load_msb", 32'(load_m), 32'(e_load));
      chk("busy", 32'(busy_l), 32'(e_busy));
      chk("restart", 32'(rst_l), 32'(e_restart));
      chk("busy_msb", 32'(busy_m), 32'(e_busy));
      chk("restart_msb", 32'(rst_m), 32'(e_restart));
      if (load_l) begin
         prev_load = last_load;
         last_load = cyc;
         loads_seen++;
      end
   endtask

   task automatic do_start();
      start_cyc = cyc;
      step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Send the word LSB-first on the wire; optional one idle cycle between bits
   task automatic send_bits(input logic [N-1:0] w, input bit gap, input int unsigned cnt);
      for (int i = 0; i < int'(cnt); i++) begin
         step(1'b0, 1'b1, w[i], 1'b0);
         if (gap && i < int'(cnt) - 1) step(1'b0, 1'b0, 1'($urandom), 1'b0);
      end
   endtask

   initial begin
      int l0;
      start = 0; dvalid = 0; dbit = 0; res = 0;
      last_load = 0; prev_load = 0; loads_seen = 0; start_cyc = 0;

      // Reset state
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset_word", 32'(word_l), 32'h0);
      step(1'b0, 1'b1, 1'b1, 1'b0);

      // LSB-first single frame 0xA5
      do_start();
      send_bits(8'hA5, 1'b0, N);
      chk("a5_word", 32'(word_l), 32'hA5);
      chk("a5_latency", 32'(last_load - start_cyc), 32'd9);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Bit order 1,0,0,...
      do_start();
      send_bits(8'h01, 1'b0, N);
      chk("order_lsb", 32'(word_l), 32'h01);
      chk("order_msb", 32'(word_m), 32'h80);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Gapped valid
      do_start();
      send_bits(8'hA5, 1'b1, N);
      chk("gap_word", 32'(word_l), 32'hA5);
      chk("gap_latency", 32'(last_load - start_cyc), 32'd16);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Abort after 3 bits with a valid 1 alongside the strobe
      do_start();
      send_bits(8'h00, 1'b0, 3);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("abort_restart", 32'(rst_l), 32'd1);
      chk("abort_busy", 32'(busy_l), 32'd1);
      l0 = loads_seen;
      send_bits(8'hFF, 1'b0, N);
      chk("abort_word", 32'(word_l), 32'hFF);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("abort_loads", 32'(loads_seen - l0), 32'd1);

      // Back-to-back frames
      do_start();
      send_bits(8'h12, 1'b0, N);
      chk("b2b_word0", 32'(word_l), 32'h12);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      send_bits(8'h34, 1'b0, N);
      chk("b2b_word1", 32'(word_l), 32'h34);
      chk("b2b_spacing", 32'(last_load - prev_load), 32'd9);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Reset mid-frame, then bits without start, then a fresh frame
      do_start();
      send_bits(8'h1F, 1'b0, 5);
      l0 = loads_seen;
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("res_word", 32'(word_l), 32'h0);
      chk("res_busy", 32'(busy_l), 32'd0);
      send_bits(8'hFF, 1'b0, N);
      chk("res_noload", 32'(loads_seen - l0), 32'd0);
      do_start();
      send_bits(8'h5A, 1'b0, N);
      chk("res_5a", 32'(word_l), 32'h5A);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         step(1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom), 1'($urandom_range(0, 79) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
